// File: rtl/nios_keycode_pkg.sv
// Shared register map for the keycode input port: offsets and bit positions.
// Imported by the top-level block; holds constants only.
package nios_keycode_pkg;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_IRQMASK = 2'd2;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 8;
    localparam int ST_CNT_W   = 8;

    localparam int DATA_VLD = 31;

endpackage

// File: rtl/keycode_fifo.sv
// Keycode FIFO: register array with wrapping pointers and an occupancy count.
// Latency: head visible the cycle after a push into an empty FIFO.
// Backpressure: push is dropped when full unless paired with a pop; pop is ignored when empty.
module keycode_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            // Pointer pow-2 wrap is free; count saturates naturally because push is gated at full.
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nios_system_keycode_in.sv
// Avalon-MM keycode input port: front-end strobes keycodes into a FIFO, Nios pops via DATA.
// Latency: readdata is combinational (read latency 0); irq registered one cycle. Optional irq: KEYCODE_IN_IRQ_EN.
// Backpressure: none toward the front-end; keycodes pushed while full are dropped and flag sticky overflow.
module nios_system_keycode_in
    import nios_keycode_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [DATA_W-1:0] in_keycode,
    input  logic              in_valid
`ifdef KEYCODE_IN_IRQ_EN
    ,
    output logic              irq
`endif
);

    logic [DATA_W-1:0] head;
    logic              empty;
    logic              full;
    logic [CNT_W-1:0]  count;
    logic              rd_data_sel;
    logic              wr_status_sel;
    logic              pop;
    logic              push;
    logic              ovf_set;
    logic              ovf_clr;
    logic              overflow;
    logic              irqmask_q;
    logic              unused_wdata;

    assign rd_data_sel   = chipselect & ~read_n & (address == REG_DATA);
    assign wr_status_sel = chipselect & ~write_n & (address == REG_STATUS);

    // A DATA read on an empty FIFO must not pop, so a same-cycle push into empty still lands.
    assign pop     = rd_data_sel & ~empty;
    assign push    = in_valid & (~full | pop);
    assign ovf_set = in_valid & full & ~pop;
    assign ovf_clr = wr_status_sel & writedata[ST_OVF];

    assign unused_wdata = ^{writedata[31:3], writedata[1:0]};

    keycode_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wdata   (in_keycode),
        .rdata   (head),
        .empty   (empty),
        .full    (full),
        .count   (count)
    );

    // Set takes priority over a same-cycle software clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else begin
            overflow <= ovf_set | (overflow & ~ovf_clr);
        end
    end

`ifdef KEYCODE_IN_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_q <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (chipselect & ~write_n & (address == REG_IRQMASK)) begin
                irqmask_q <= writedata[0];
            end
            irq <= irqmask_q & (~empty | overflow);
        end
    end
`else
    assign irqmask_q = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            REG_DATA: begin
                if (!empty) begin
                    readdata[DATA_W-1:0] = head;
                    readdata[DATA_VLD]   = 1'b1;
                end
            end
            REG_STATUS: begin
                readdata[ST_EMPTY]                  = empty;
                readdata[ST_FULL]                   = full;
                readdata[ST_OVF]                    = overflow;
                readdata[ST_CNT_LSB +: ST_CNT_W]    = ST_CNT_W'(count);
            end
            REG_IRQMASK: readdata[0] = irqmask_q;
            default:     readdata = '0;
        endcase
    end

endmodule
